// File: rtl/wallace_seq_mult_ctrl_pkg.sv
// Shared types and constants for the sequential shift-add multiplier controller.
package wallace_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 8;

  // Row counter must hold WIDTH-1 without wrapping.
  function automatic int cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/wallace_seq_mult_ctrl_if.sv
// Operand/product valid-ready bundle between source, multiplier controller and consumer.
interface wallace_seq_mult_ctrl_if #(
  parameter int WIDTH = wallace_seq_pkg::DEFAULT_WIDTH
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] product;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, product
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, product
  );
endinterface

// File: rtl/wallace_seq_mult_ctrl_mult_acc_step.sv
// Combinational single partial-product row: conditional add, then shift both operands.
// Optional WALLACE_SEQ_EARLY_TERM_EN adds the post-shift multiplier-zero flag.
module mult_acc_step #(
  parameter int WIDTH = 8
) (
  input  logic [2*WIDTH-1:0] mcand,
  input  logic [WIDTH-1:0]   mplier,
  input  logic [2*WIDTH-1:0] acc,
  output logic [2*WIDTH-1:0] mcand_nxt,
  output logic [WIDTH-1:0]   mplier_nxt,
`ifdef WALLACE_SEQ_EARLY_TERM_EN
  output logic               mplier_zero,
`endif
  output logic [2*WIDTH-1:0] acc_nxt
);

  always_comb begin
    mcand_nxt  = mcand << 1;
    mplier_nxt = mplier >> 1;
    acc_nxt    = mplier[0] ? (acc + mcand) : acc;
  end

`ifdef WALLACE_SEQ_EARLY_TERM_EN
  assign mplier_zero = (mplier_nxt == '0);
`endif

endmodule

// File: rtl/wallace_seq_mult_ctrl.sv
// Sequential shift-add multiplier controller: one partial-product row per clock.
// Define WALLACE_SEQ_EARLY_TERM_EN to finish as soon as the remaining multiplier is zero.
module wallace_seq_mult_ctrl
  import wallace_seq_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  wallace_seq_mult_ctrl_if.slave bus,
  output logic                   busy
);

  localparam int CNT_W = cnt_w(WIDTH);
  localparam int PW    = 2 * WIDTH;

  state_t              state_q, state_d;
  logic [PW-1:0]       mcand_q, mcand_d;
  logic [WIDTH-1:0]    mplier_q, mplier_d;
  logic [PW-1:0]       acc_q, acc_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic [PW-1:0]       step_mcand;
  logic [WIDTH-1:0]    step_mplier;
  logic [PW-1:0]       step_acc;
  logic                in_ready_w;
`ifdef WALLACE_SEQ_EARLY_TERM_EN
  logic                step_zero;
`endif

  mult_acc_step #(.WIDTH(WIDTH)) u_step (
    .mcand      (mcand_q),
    .mplier     (mplier_q),
    .acc        (acc_q),
    .mcand_nxt  (step_mcand),
    .mplier_nxt (step_mplier),
`ifdef WALLACE_SEQ_EARLY_TERM_EN
    .mplier_zero(step_zero),
`endif
    .acc_nxt    (step_acc)
  );

  // Gated with rst so nothing looks acceptable while reset is held.
  assign in_ready_w    = (state_q == IDLE) && !rst;
  assign bus.in_ready  = in_ready_w;
  assign bus.out_valid = (state_q == DONE);
  assign bus.product   = (state_q == DONE) ? acc_q : '0;
  assign busy          = (state_q == RUN) || (state_q == DONE);

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid && in_ready_w) begin
          mcand_d  = {{WIDTH{1'b0}}, bus.a};
          mplier_d = bus.b;
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        mcand_d  = step_mcand;
        mplier_d = step_mplier;
        acc_d    = step_acc;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(WIDTH - 1)) state_d = DONE;
`ifdef WALLACE_SEQ_EARLY_TERM_EN
        if (step_zero) state_d = DONE;
`endif
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule
